// File: rtl/div_32bit_seq_pkg.sv
// Shared definitions for the sequential signed divider.
//   DIV_WIDTH  : operand/result width (only 32 is supported)
//   DIV_ITER   : quotient iterations, one bit per cycle
//   CNT_W      : iteration counter width (must hold DIV_ITER)
//   div_state_e: divider FSM states
//   div_exception(): divide-by-zero / signed-overflow detect
package div_32bit_seq_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITER  = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Exception when the divisor is zero, or for the single quotient
  // (-2^31 / -1) that is not representable in 32-bit two's complement.
  function automatic logic div_exception(
    input logic [DIV_WIDTH-1:0] a,
    input logic [DIV_WIDTH-1:0] b
  );
    logic b_zero;
    logic a_min;
    logic b_neg1;
    b_zero = (b == '0);
    a_min  = (a == {1'b1, {(DIV_WIDTH-1){1'b0}}});
    b_neg1 = (b == '1);
    return b_zero | (a_min & b_neg1);
  endfunction

endpackage

// File: rtl/div_32bit_seq_negate.sv
// Combinational two's-complement negation: out = ~in + 1.
// Shared with the ALU subtract path.
//   in_val  : value to negate
//   out_val : two's-complement negation of in_val
module negate_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] out_val
);

  always_comb begin
    out_val = ~in_val + WIDTH'(1);
  end

endmodule

// File: rtl/div_32bit_seq.sv
// Multicycle signed 32-bit restoring divider.
// Operands are converted to magnitudes on the start edge, 32 quotient
// bits are produced one per cycle, and the quotient is re-signed on the
// completion edge. Result and exception are registered and held until the
// next completion or reset; data_resultRDY pulses for one cycle.
//   clock          : rising-edge clock
//   reset          : synchronous, active-high reset
//   ctrl_DIV       : start pulse; operands sampled on the edge it is high
//   data_operandA  : dividend (signed)
//   data_operandB  : divisor (signed)
//   data_result    : signed quotient, truncated toward zero
//   data_exception : divide-by-zero or overflow, valid with data_resultRDY
//   data_resultRDY : one-cycle completion pulse
module div_32bit_seq
  import div_32bit_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned ITER  = DIV_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  div_state_e       state_q,  state_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0] rem_q,    rem_d;
  logic [WIDTH-1:0] quot_q,   quot_d;
  logic [WIDTH-1:0] abs_b_q,  abs_b_d;
  logic             qsign_q,  qsign_d;
  logic             exc_q,    exc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dexc_q,   dexc_d;
  logic             rdy_q,    rdy_d;

  logic [WIDTH-1:0] neg_a;
  logic [WIDTH-1:0] neg_b;
  logic [WIDTH-1:0] neg_quot;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  negate_32bit #(.WIDTH(WIDTH)) u_neg_a (
    .in_val  (data_operandA),
    .out_val (neg_a)
  );

  negate_32bit #(.WIDTH(WIDTH)) u_neg_b (
    .in_val  (data_operandB),
    .out_val (neg_b)
  );

  negate_32bit #(.WIDTH(WIDTH)) u_neg_q (
    .in_val  (quot_q),
    .out_val (neg_quot)
  );

  // -2^31 negates to itself; read as unsigned it is the correct magnitude.
  assign abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

  // The remainder is always below |B| <= 2^31, so the shifted value stays
  // under 2^32 and bit WIDTH of the difference is a true sign bit.
  assign rem_shift = {rem_q, quot_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, abs_b_q};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    abs_b_d  = abs_b_q;
    qsign_d  = qsign_q;
    exc_d    = exc_q;
    result_d = result_q;
    dexc_d   = dexc_q;
    rdy_d    = 1'b0;

    if (ctrl_DIV) begin
      // A start in any state discards whatever was in flight.
      rem_d   = '0;
      quot_d  = abs_a;
      abs_b_d = abs_b;
      qsign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      exc_d   = div_exception(data_operandA, data_operandB);
      count_d = '0;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          if (count_q == CNT_W'(ITER)) begin
            result_d = exc_q ? '0 : (qsign_q ? neg_quot : quot_q);
            dexc_d   = exc_q;
            rdy_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            quot_d  = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_d   = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
            count_d = count_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      abs_b_q  <= '0;
      qsign_q  <= 1'b0;
      exc_q    <= 1'b0;
      result_q <= '0;
      dexc_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      abs_b_q  <= abs_b_d;
      qsign_q  <= qsign_d;
      exc_q    <= exc_d;
      result_q <= result_d;
      dexc_q   <= dexc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = dexc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed testbench for div_32bit_seq.
module tb_div_32bit_seq;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks;
  int errors;
  int pulses;

  div_32bit_seq #(.WIDTH(32), .ITER(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count ready pulses independently of the directed sequence.
  initial pulses = 0;
  always @(negedge clock) begin
    if (data_resultRDY === 1'b1) pulses = pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
  endtask

  // Called right after start_op returns (just past edge E0).
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic exp_exc);
    int early;
    early = 0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY !== 1'b0) early = early + 1;
    end
    chk({tag, "_early_rdy"}, 32'(early), 32'd0);
    @(posedge clock);
    #1;
    chk({tag, "_rdy"}, {31'd0, data_resultRDY}, 32'd1);
    chk({tag, "_result"}, data_result, exp_res);
    chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    @(posedge clock);
    #1;
    chk({tag, "_rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
    chk({tag, "_hold"}, data_result, exp_res);
  endtask

  initial begin
    int p0;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;

    // Reset wins over a simultaneous start.
    repeat (3) @(posedge clock);
    #1;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    ctrl_DIV = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("reset_no_pulse", 32'(pulses), 32'd0);

    start_op(32'd100, 32'd7);
    wait_done("p100_7", 32'd14, 1'b0);

    start_op(32'hFFFF_FF9C, 32'd7);
    wait_done("m100_7", 32'hFFFF_FFF2, 1'b0);

    start_op(32'd7, 32'hFFFF_FF9C);
    wait_done("p7_m100", 32'd0, 1'b0);

    start_op(32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done("m100_m7", 32'd14, 1'b0);

    start_op(32'd5, 32'd0);
    wait_done("div_zero", 32'd0, 1'b1);

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("overflow", 32'd0, 1'b1);

    start_op(32'h8000_0000, 32'd1);
    wait_done("min_by_1", 32'h8000_0000, 1'b0);

    // Restart mid-operation: only the second operation completes.
    p0 = pulses;
    start_op(32'd100, 32'd7);
    repeat (10) @(posedge clock);
    start_op(32'd9, 32'd3);
    wait_done("restart", 32'd3, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    chk("restart_one_pulse", 32'(pulses), 32'(p0 + 1));

    // Reset mid-operation: outputs clear, no pulse follows.
    p0 = pulses;
    start_op(32'd100, 32'd7);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_result", data_result, 32'd0);
    chk("abort_exc", {31'd0, data_exception}, 32'd0);
    chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("abort_no_pulse", 32'(pulses), 32'(p0));

    start_op(32'h7FFF_FFFF, 32'd2);
    wait_done("max_by_2", 32'h3FFF_FFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
